// File: rtl/heq_pkg.sv
// Shared definitions for the histogram-equalisation frame sequencer.
// Phase encoding, unit index constants and phase lookup helpers.
package heq_pkg;

    localparam int unsigned NUM_UNITS = 4;

    localparam int unsigned HIST = 0;
    localparam int unsigned CDF  = 1;
    localparam int unsigned DIV  = 2;
    localparam int unsigned MAP  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIST = 3'd1,
        ST_CDF  = 3'd2,
        ST_DIV  = 3'd3,
        ST_MAP  = 3'd4,
        ST_FIN  = 3'd5
    } phase_t;

    typedef enum logic [2:0] {
        OWN_HIST = 3'd0,
        OWN_CDF  = 3'd1,
        OWN_DIV  = 3'd2,
        OWN_MAP  = 3'd3,
        OWN_NONE = 3'd4
    } owner_t;

    // Phase that follows a processing phase; anything else falls back to IDLE.
    function automatic phase_t next_phase(input phase_t p);
        phase_t r;
        r = ST_IDLE;
        case (p)
            ST_HIST: r = ST_CDF;
            ST_CDF:  r = ST_DIV;
            ST_DIV:  r = ST_MAP;
            ST_MAP:  r = ST_FIN;
            default: r = ST_IDLE;
        endcase
        return r;
    endfunction

    // Scratch port owner for a phase; IDLE/FIN own nothing.
    function automatic owner_t phase_owner(input phase_t p);
        owner_t r;
        r = OWN_NONE;
        case (p)
            ST_HIST: r = OWN_HIST;
            ST_CDF:  r = OWN_CDF;
            ST_DIV:  r = OWN_DIV;
            ST_MAP:  r = OWN_MAP;
            default: r = OWN_NONE;
        endcase
        return r;
    endfunction

    // Unit index serviced by a processing phase.
    function automatic logic [1:0] phase_unit(input phase_t p);
        logic [1:0] r;
        r = 2'(HIST);
        case (p)
            ST_CDF:  r = 2'(CDF);
            ST_DIV:  r = 2'(DIV);
            ST_MAP:  r = 2'(MAP);
            default: r = 2'(HIST);
        endcase
        return r;
    endfunction

    // One-hot unit enable for the first cycle of a phase.
    function automatic logic [NUM_UNITS-1:0] phase_onehot(input phase_t p);
        logic [NUM_UNITS-1:0] r;
        r = '0;
        case (p)
            ST_HIST: r[HIST] = 1'b1;
            ST_CDF:  r[CDF]  = 1'b1;
            ST_DIV:  r[DIV]  = 1'b1;
            ST_MAP:  r[MAP]  = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/heq_sc_port_mux.sv
// Scratch memory port selector: routes the owning unit's address/data/WE
// to the single scratch port. MAP is read-only, so its write enable is masked.
module heq_sc_port_mux
    import heq_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 128
) (
    input  owner_t                          owner,
    input  logic [NUM_UNITS*ADDR_W-1:0]     req_rd_addr1,
    input  logic [NUM_UNITS*ADDR_W-1:0]     req_rd_addr2,
    input  logic [NUM_UNITS*ADDR_W-1:0]     req_wt_addr,
    input  logic [NUM_UNITS*DATA_W-1:0]     req_wt_data,
    input  logic [NUM_UNITS-1:0]            req_wt_en,
    output logic [ADDR_W-1:0]               sc_rd_addr1,
    output logic [ADDR_W-1:0]               sc_rd_addr2,
    output logic [ADDR_W-1:0]               sc_wt_addr,
    output logic [DATA_W-1:0]               sc_wt_data,
    output logic                            sc_wt_en
);

    // Select the owner's slice; no owner drives an idle (all-zero) port.
    always_comb begin
        sc_rd_addr1 = '0;
        sc_rd_addr2 = '0;
        sc_wt_addr  = '0;
        sc_wt_data  = '0;
        sc_wt_en    = 1'b0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (32'(owner) == i) begin
                sc_rd_addr1 = req_rd_addr1[i*ADDR_W +: ADDR_W];
                sc_rd_addr2 = req_rd_addr2[i*ADDR_W +: ADDR_W];
                sc_wt_addr  = req_wt_addr[i*ADDR_W +: ADDR_W];
                sc_wt_data  = req_wt_data[i*DATA_W +: DATA_W];
                sc_wt_en    = req_wt_en[i] && (owner != OWN_MAP);
            end
        end
    end

endmodule

// File: rtl/heq_phase_sched.sv
// Frame sequencer for histogram equalisation: HIST -> CDF -> DIV -> MAP.
// Grants the shared scratch port to the active unit and latches cdf_min.
// Optional per-phase watchdog enabled by defining HEQ_WATCHDOG_EN.
module heq_phase_sched
    import heq_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            err,
    output logic [NUM_UNITS-1:0]            unit_en,
    input  logic [NUM_UNITS-1:0]            unit_done,
    input  logic [31:0]                     cdf_min_in,
    output logic [31:0]                     cdf_min,
    input  logic [NUM_UNITS*ADDR_W-1:0]     req_rd_addr1,
    input  logic [NUM_UNITS*ADDR_W-1:0]     req_rd_addr2,
    input  logic [NUM_UNITS*ADDR_W-1:0]     req_wt_addr,
    input  logic [NUM_UNITS*DATA_W-1:0]     req_wt_data,
    input  logic [NUM_UNITS-1:0]            req_wt_en,
    output logic [ADDR_W-1:0]               sc_rd_addr1,
    output logic [ADDR_W-1:0]               sc_rd_addr2,
    output logic [ADDR_W-1:0]               sc_wt_addr,
    output logic [DATA_W-1:0]               sc_wt_data,
    output logic                            sc_wt_en
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("heq_phase_sched: TIMEOUT_CYCLES must be at least 2");
    end

    phase_t state;
    owner_t owner;
    phase_t next_c;
    logic   in_phase_c;
    logic   phase_done_c;
    logic   timeout_c;

    assign in_phase_c   = (state == ST_HIST) || (state == ST_CDF) ||
                          (state == ST_DIV)  || (state == ST_MAP);
    assign phase_done_c = in_phase_c && unit_done[phase_unit(state)];
    assign next_c       = next_phase(state);

    // Phase sequencing, unit start pulses, status flags and cdf_min latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            unit_en    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cdf_min    <= '0;
        end else begin
            unit_en    <= '0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_HIST;
                        owner   <= OWN_HIST;
                        unit_en <= phase_onehot(ST_HIST);
                        busy    <= 1'b1;
                    end
                end
                ST_HIST, ST_CDF, ST_DIV, ST_MAP: begin
                    if (phase_done_c) begin
                        if (state == ST_CDF) begin
                            cdf_min <= cdf_min_in;
                        end
                        state      <= next_c;
                        owner      <= phase_owner(next_c);
                        unit_en    <= phase_onehot(next_c);
                        busy       <= (next_c != ST_FIN);
                        frame_done <= (next_c == ST_FIN);
                    end else if (timeout_c) begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                        busy  <= 1'b0;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HEQ_WATCHDOG_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wd_cnt;

    assign timeout_c = in_phase_c && !phase_done_c &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Per-phase cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (!in_phase_c || phase_done_c || timeout_c) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (timeout_c) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout_c = 1'b0;
    assign err       = 1'b0;
`endif

    heq_sc_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sc_mux (
        .owner        (owner),
        .req_rd_addr1 (req_rd_addr1),
        .req_rd_addr2 (req_rd_addr2),
        .req_wt_addr  (req_wt_addr),
        .req_wt_data  (req_wt_data),
        .req_wt_en    (req_wt_en),
        .sc_rd_addr1  (sc_rd_addr1),
        .sc_rd_addr2  (sc_rd_addr2),
        .sc_wt_addr   (sc_wt_addr),
        .sc_wt_data   (sc_wt_data),
        .sc_wt_en     (sc_wt_en)
    );

endmodule
